mac_seq_3a: RTL and testbench

MAC_SEQ_3A -- requirements
Module: mac_seq_3a

---
 rtl/mac_seq_3a_pkg.sv | 29 ++
 rtl/mac_seq_3a_if.sv | 37 +++
 rtl/mac_seq_3a_delay.sv | 43 ++++
 rtl/mac_seq_3a.sv | 145 ++++++++++++++
 tb/tb_mac_seq_3a.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_seq_3a_pkg.sv
// Shared types and constants for the MAC sequencer: FSM states, DSP OPMODE
// encodings and the helper that picks the OPMODE for an issued term.
package mac_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // DSP OPMODE values driven towards the DSP OPMODE input
    localparam logic [6:0] OPM_MUL_C   = 7'h35;  // P = A*B + C
    localparam logic [6:0] OPM_MUL     = 7'h05;  // P = A*B
    localparam logic [6:0] OPM_MUL_ACC = 7'h25;  // P = A*B + P
    localparam logic [6:0] OPM_HOLD    = 7'h20;  // P = P
    localparam logic [6:0] OPM_ZERO    = 7'h00;  // reset / cleared value

    // OPMODE for a cycle in which a term is issued
    function automatic logic [6:0] issue_opmode(input logic first, input logic use_c);
        logic [6:0] opm;
        if (first) begin
            opm = use_c ? OPM_MUL_C : OPM_MUL;
        end else begin
            opm = OPM_MUL_ACC;
        end
        return opm;
    endfunction

endpackage

// File: rtl/mac_seq_3a_if.sv
// Bus between the requester/DSP side and the MAC sequencer.
//
// Handshake: op_valid_i is raised by the requester when A/B are on the DSP
// inputs; op_ready_o is raised by the sequencer in the same cycle only while
// it is issuing terms. A term is consumed (issued) in every cycle where both
// are high; idx_o names the term being asked for and advances after each issue.
// There is no back-pressure on the result: result_valid_o is a single-cycle
// pulse and must be captured in that cycle.
interface mac_seq_3a_if #(
    parameter int LEN_W = 6
);
    logic             start_i;
    logic [LEN_W-1:0] len_i;
    logic             use_c_i;
    logic             op_valid_i;
    logic             op_ready_o;
    logic [LEN_W-1:0] idx_o;
    logic [6:0]       OPMODE_o;
    logic             CREG_en_o;
    logic             busy_o;
    logic             result_valid_o;
    mac_seq_pkg::state_e dbg_state;

    // requester / DSP-driving side
    modport master (
        output start_i, len_i, use_c_i, op_valid_i,
        input  op_ready_o, idx_o, OPMODE_o, CREG_en_o, busy_o, result_valid_o,
        input  dbg_state
    );

    // sequencer side
    modport slave (
        input  start_i, len_i, use_c_i, op_valid_i,
        output op_ready_o, idx_o, OPMODE_o, CREG_en_o, busy_o, result_valid_o,
        output dbg_state
    );
endinterface

// File: rtl/mac_seq_3a_delay.sv
// Fixed-depth 7-bit delay line for OPMODE values. Aligns the OPMODE chosen in
// the issue cycle with the arrival of the matching product at the DSP ALU.
// A depth of zero is a straight wire.
module opmode_delay_line
    import mac_seq_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic [6:0] opm_i,
    output logic [6:0] opm_o
);

    if (DEPTH == 0) begin : g_pass
        assign opm_o = opm_i;
    end else begin : g_pipe
        logic [6:0] pipe_q [DEPTH];
        logic [6:0] pipe_d [DEPTH];

        // shift: new value enters stage 0, every stage moves one along
        always_comb begin
            pipe_d[0] = opm_i;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_d[i] = pipe_q[i-1];
            end
        end

        // stage registers, cleared synchronously to the zero OPMODE
        always_ff @(posedge clock_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (reset_i) begin
                    pipe_q[i] <= OPM_ZERO;
                end else begin
                    pipe_q[i] <= pipe_d[i];
                end
            end
        end

        assign opm_o = pipe_q[DEPTH-1];
    end

endmodule

// File: rtl/mac_seq_3a.sv
// MAC sequencer: walks a DSP through N multiply(-accumulate) terms. It hands
// out operand requests, schedules OPMODE through a delay line so it meets the
// matching product inside the DSP, pulses the C-register enable for the
// optional C addend, and flags when P holds the final sum.
module mac_seq_3a
    import mac_seq_pkg::*;
#(
    parameter int ABREG = 1,
    parameter int MREG  = 1,
    parameter int CREG  = 1,
    parameter int LEN_W = 6
) (
    input  logic        clock_i,
    input  logic        reset_i,
    mac_seq_3a_if.slave bus
);

    // DSP pipeline depth between operands at the input and the ALU
    localparam int PIPE      = ABREG + MREG;
    // OPMODE is itself registered inside the DSP, hence one stage less
    localparam int OPM_DLY   = (PIPE > 0) ? PIPE - 1 : 0;
    // cycles after the last issue until P carries the final sum
    localparam int DRAIN_LEN = 1 + PIPE;
    // C must be captured so it reaches the ALU with the first product
    localparam int CREG_DLY  = (PIPE > CREG) ? PIPE - CREG : 0;
    localparam int CSR_W     = (CREG_DLY > 0) ? CREG_DLY : 1;
    localparam int DRAIN_W   = 3;

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   idx_q, idx_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               use_c_q, use_c_d;
    logic               first_q, first_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic [CSR_W-1:0]   creg_sr_q, creg_sr_d;

    logic               issue;
    logic               op_ready;
    logic               busy;
    logic               result_valid;
    logic               creg_pulse;
    logic               creg_en;
    logic [6:0]         opm_in;
    logic [6:0]         opm_out;

    // next-state, handshake and OPMODE selection
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        len_d        = len_q;
        use_c_d      = use_c_q;
        first_d      = first_q;
        drain_d      = drain_q;
        op_ready     = 1'b0;
        issue        = 1'b0;
        result_valid = 1'b0;
        opm_in       = OPM_HOLD;
        busy         = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                // a zero-length request has nothing to compute and is dropped
                if (bus.start_i && (bus.len_i != '0)) begin
                    state_d = ST_ISSUE;
                    len_d   = bus.len_i;
                    use_c_d = bus.use_c_i;
                    idx_d   = '0;
                    first_d = 1'b1;
                end
            end
            ST_ISSUE: begin
                op_ready = bus.op_valid_i;
                issue    = bus.op_valid_i;
                if (issue) begin
                    opm_in  = issue_opmode(first_q, use_c_q);
                    first_d = 1'b0;
                    if (idx_q == len_q - LEN_W'(1)) begin
                        state_d = ST_DRAIN;
                        idx_d   = '0;
                        drain_d = DRAIN_W'(DRAIN_LEN - 1);
                    end else begin
                        idx_d = idx_q + LEN_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) begin
                    result_valid = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    drain_d = drain_q - DRAIN_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // C-register enable: mark the first issue of a use_c run, then delay it
    always_comb begin
        creg_pulse = issue & first_q & use_c_q;
        creg_sr_d  = CSR_W'({creg_sr_q, creg_pulse});
        creg_en    = (CREG_DLY == 0) ? creg_pulse : creg_sr_q[CSR_W-1];
    end

    // state registers with synchronous reset; reset also aborts a run silently
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            len_q     <= '0;
            use_c_q   <= 1'b0;
            first_q   <= 1'b0;
            drain_q   <= '0;
            creg_sr_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            use_c_q   <= use_c_d;
            first_q   <= first_d;
            drain_q   <= drain_d;
            creg_sr_q <= creg_sr_d;
        end
    end

    opmode_delay_line #(
        .DEPTH (OPM_DLY)
    ) u_opm_dly (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .opm_i   (opm_in),
        .opm_o   (opm_out)
    );

    assign bus.op_ready_o     = op_ready;
    assign bus.idx_o          = idx_q;
    assign bus.OPMODE_o       = opm_out;
    assign bus.CREG_en_o      = creg_en;
    assign bus.busy_o         = busy;
    assign bus.result_valid_o = result_valid;
    assign bus.dbg_state      = state_q;

endmodule

// File: tb/tb_mac_seq_3a.sv
// Bench for mac_seq_3a with a small register-level DSP model attached to the
// OPMODE / CREG_en outputs, so the final P value can be checked against the
// plain arithmetic sum of the issued products.
module tb_mac_seq_3a;
  import mac_seq_pkg::*;

  localparam int ABREG = 1;
  localparam int MREG  = 1;
  localparam int CREG  = 1;
  localparam int LEN_W = 6;
  localparam int D        = ABREG + MREG;
  localparam int DLY      = (D > 0) ? D - 1 : 0;
  localparam int L        = 1 + D;
  localparam int CREG_OFF = (D > CREG) ? D - CREG : 0;
  localparam logic [47:0] C_VAL = 48'd100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mac_seq_3a_if #(.LEN_W(LEN_W)) bus ();

  mac_seq_3a #(
    .ABREG (ABREG),
    .MREG  (MREG),
    .CREG  (CREG),
    .LEN_W (LEN_W)
  ) dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  // ---------------- DSP model (AREG/BREG=1, MREG=1, CREG=1, OPMODEREG=1) ----
  logic [24:0] a_drv;
  logic [17:0] b_drv;
  logic [24:0] a_r;
  logic [17:0] b_r;
  logic [47:0] m_r, c_r, p_r;
  logic [6:0]  opm_r;

  always @(posedge clk) begin
    a_r   <= a_drv;
    b_r   <= b_drv;
    m_r   <= 48'(a_r) * 48'(b_r);
    opm_r <= bus.OPMODE_o;
    if (bus.CREG_en_o) c_r <= C_VAL;
    case (opm_r)
      7'h35:   p_r <= m_r + c_r;
      7'h05:   p_r <= m_r;
      7'h25:   p_r <= p_r + m_r;
      7'h20:   p_r <= p_r;
      default: p_r <= 48'd0;
    endcase
  end

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- driver + reference model for one sequence ----------------
  // vmode: 0 valid always, 1 random valid, 2 valid except bub_len cycles once
  // bub_at terms are issued. amode: 0 A=k+1,B=2; 1 A=B=3; 2 random.
  task automatic run_seq(input int n, input bit use_c, input int amode, input int vmode,
                         input int bub_at, input int bub_len, input bit noise,
                         output int rv_rel);
    logic [6:0]  exp_q[$];
    logic [6:0]  kind, exp_opm;
    logic [47:0] exp_p;
    state_e      exp_st;
    int issued, t0, jlast, bub_cnt, rv_cyc;
    bit in_issue, valid, iss, exp_rv, exp_creg, done;
    issued = 0; t0 = -1; jlast = -1; bub_cnt = 0; rv_cyc = -1; done = 0;
    exp_p = use_c ? C_VAL : 48'd0;
    for (int i = 0; i < DLY; i++) exp_q.push_back(OPM_HOLD);
    for (int j = 0; j < 400 && !done; j++) begin
      @(negedge clk);
      in_issue = (j >= 1) && (issued < n);
      if (j == 0) begin
        bus.start_i = 1'b1; bus.len_i = LEN_W'(n); bus.use_c_i = use_c;
      end else begin
        bus.start_i = noise ? ($urandom_range(0, 1) == 1) : 1'b0;
        bus.len_i   = LEN_W'($urandom_range(0, 63));
        bus.use_c_i = ($urandom_range(0, 1) == 1);
      end
      if (in_issue) begin
        case (vmode)
          0: valid = 1'b1;
          1: valid = ($urandom_range(0, 9) < 7);
          default: valid = !(issued == bub_at && bub_cnt < bub_len);
        endcase
        if (vmode == 2 && !valid) bub_cnt++;
      end else begin
        valid = ($urandom_range(0, 1) == 1);
      end
      bus.op_valid_i = valid;
      iss = in_issue && valid;
      if (iss && amode == 0) begin a_drv = 25'(issued + 1); b_drv = 18'd2; end
      else if (iss && amode == 1) begin a_drv = 25'd3; b_drv = 18'd3; end
      else begin a_drv = 25'($urandom_range(0, 4095)); b_drv = 18'($urandom_range(0, 4095)); end
      if (iss && issued == 0) t0 = j;
      if (iss) exp_p = exp_p + 48'(a_drv) * 48'(b_drv);
      if (!iss) kind = OPM_HOLD;
      else if (issued == 0) kind = use_c ? OPM_MUL_C : OPM_MUL;
      else kind = OPM_MUL_ACC;
      exp_q.push_back(kind);
      exp_opm  = exp_q.pop_front();
      exp_rv   = (jlast >= 0) && (j == jlast + L);
      exp_creg = use_c && (t0 >= 0) && (j == t0 + CREG_OFF);
      exp_st   = (j == 0) ? ST_IDLE : (in_issue ? ST_ISSUE : ST_DRAIN);
      #1;
      n_tests++;
      if (bus.op_ready_o !== iss) begin
        n_fail++; $display("FAIL op_ready cyc %0d: got %b expected %b", j, bus.op_ready_o, iss);
      end
      n_tests++;
      if (bus.busy_o !== (j >= 1)) begin
        n_fail++; $display("FAIL busy cyc %0d: got %b expected %b", j, bus.busy_o, (j >= 1));
      end
      n_tests++;
      if (bus.result_valid_o !== exp_rv) begin
        n_fail++; $display("FAIL result_valid cyc %0d: got %b expected %b", j, bus.result_valid_o, exp_rv);
      end
      n_tests++;
      if (bus.OPMODE_o !== exp_opm) begin
        n_fail++; $display("FAIL opmode cyc %0d: got %h expected %h", j, bus.OPMODE_o, exp_opm);
      end
      n_tests++;
      if (bus.CREG_en_o !== exp_creg) begin
        n_fail++; $display("FAIL creg_en cyc %0d: got %b expected %b", j, bus.CREG_en_o, exp_creg);
      end
      n_tests++;
      if (bus.dbg_state !== exp_st) begin
        n_fail++; $display("FAIL state cyc %0d: got %0d expected %0d", j, bus.dbg_state, exp_st);
      end
      if (in_issue) begin
        n_tests++;
        if (bus.idx_o !== LEN_W'(issued)) begin
          n_fail++; $display("FAIL idx cyc %0d: got %0d expected %0d", j, bus.idx_o, issued);
        end
      end
      if (exp_rv) begin
        n_tests++;
        if (p_r !== exp_p) begin
          n_fail++; $display("FAIL p_result n=%0d: got %0d expected %0d", n, p_r, exp_p);
        end
        done = 1;
      end
      if (bus.result_valid_o === 1'b1 && rv_cyc < 0) rv_cyc = j;
      if (iss) begin
        issued++;
        if (issued == n) jlast = j;
      end
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL seq_timeout n=%0d: got no result expected result_valid", n);
    end
    rv_rel = (rv_cyc >= 0 && t0 >= 0) ? rv_cyc - t0 : -1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.start_i = 1'b1; bus.len_i = 6'd5; bus.use_c_i = 1'b1; bus.op_valid_i = 1'b1;
    a_drv = '0; b_drv = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    n_tests++; if (bus.op_ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_op_ready: got %b expected 0", bus.op_ready_o); end
    n_tests++; if (bus.idx_o !== '0) begin n_fail++; $display("FAIL rst_idx: got %0d expected 0", bus.idx_o); end
    n_tests++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", bus.busy_o); end
    n_tests++; if (bus.result_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_rv: got %b expected 0", bus.result_valid_o); end
    n_tests++; if (bus.CREG_en_o !== 1'b0) begin n_fail++; $display("FAIL rst_creg: got %b expected 0", bus.CREG_en_o); end
    n_tests++; if (bus.OPMODE_o !== OPM_ZERO) begin n_fail++; $display("FAIL rst_opmode: got %h expected 00", bus.OPMODE_o); end
    n_tests++; if (bus.dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL rst_state: got %0d expected 0", bus.dbg_state); end
    rst = 1'b0; bus.start_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_tests++; if (bus.OPMODE_o !== OPM_HOLD) begin n_fail++; $display("FAIL idle_opmode: got %h expected 20", bus.OPMODE_o); end
    n_tests++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b expected 0", bus.busy_o); end
  endtask

  task automatic test_basic();
    int rel;
    run_seq(4, 1'b0, 0, 0, -1, 0, 1'b0, rel);
    n_tests++; if (rel !== 6) begin n_fail++; $display("FAIL basic_rv_time: got %0d expected 6", rel); end
  endtask

  task automatic test_use_c();
    int rel;
    run_seq(3, 1'b1, 1, 0, -1, 0, 1'b0, rel);
    n_tests++; if (rel !== 5) begin n_fail++; $display("FAIL usec_rv_time: got %0d expected 5", rel); end
  endtask

  task automatic test_bubble();
    int rel;
    run_seq(3, 1'b0, 0, 2, 2, 2, 1'b0, rel);
    n_tests++; if (rel !== 7) begin n_fail++; $display("FAIL bubble_rv_time: got %0d expected 7", rel); end
  endtask

  task automatic test_ignored_starts();
    int rel;
    @(negedge clk);
    bus.start_i = 1'b1; bus.len_i = '0; bus.use_c_i = 1'b1; bus.op_valid_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    #1;
    n_tests++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL len0_busy: got %b expected 0", bus.busy_o); end
    n_tests++; if (bus.op_ready_o !== 1'b0) begin n_fail++; $display("FAIL len0_op_ready: got %b expected 0", bus.op_ready_o); end
    n_tests++; if (bus.result_valid_o !== 1'b0) begin n_fail++; $display("FAIL len0_rv: got %b expected 0", bus.result_valid_o); end
    run_seq(5, 1'b1, 2, 0, -1, 0, 1'b1, rel);
    n_tests++; if (rel !== 7) begin n_fail++; $display("FAIL busy_start_rv_time: got %0d expected 7", rel); end
  endtask

  task automatic test_n1();
    int rel;
    run_seq(1, ($urandom_range(0, 1) == 1), 2, 0, -1, 0, 1'b0, rel);
    n_tests++; if (rel !== 3) begin n_fail++; $display("FAIL n1_rv_time: got %0d expected 3", rel); end
  endtask

  task automatic test_back_to_back();
    int rel;
    for (int r = 0; r < 8; r++) begin
      run_seq($urandom_range(1, 12), ($urandom_range(0, 1) == 1), 2, 1, -1, 0, 1'b1, rel);
    end
    run_seq(63, 1'b1, 2, 0, -1, 0, 1'b0, rel);
    n_tests++; if (rel !== 62 + L) begin n_fail++; $display("FAIL maxlen_rv_time: got %0d expected %0d", rel, 62 + L); end
  endtask

  task automatic test_reset_mid();
    int rel;
    @(negedge clk);
    bus.start_i = 1'b1; bus.len_i = 6'd5; bus.use_c_i = 1'b1; bus.op_valid_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    n_tests++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b expected 0", bus.busy_o); end
    n_tests++; if (bus.op_ready_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst_op_ready: got %b expected 0", bus.op_ready_o); end
    n_tests++; if (bus.idx_o !== '0) begin n_fail++; $display("FAIL mid_rst_idx: got %0d expected 0", bus.idx_o); end
    n_tests++; if (bus.OPMODE_o !== OPM_ZERO) begin n_fail++; $display("FAIL mid_rst_opmode: got %h expected 00", bus.OPMODE_o); end
    n_tests++; if (bus.CREG_en_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst_creg: got %b expected 0", bus.CREG_en_o); end
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      bus.op_valid_i = ($urandom_range(0, 1) == 1);
      #1;
      n_tests++; if (bus.result_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
        n_fail++; $display("FAIL post_rst_quiet cyc %0d: got rv=%b busy=%b expected 0 0", k, bus.result_valid_o, bus.busy_o);
      end
    end
    run_seq(1, 1'b0, 2, 0, -1, 0, 1'b0, rel);
    n_tests++; if (rel !== 3) begin n_fail++; $display("FAIL post_rst_rv_time: got %0d expected 3", rel); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected summary");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start_i = 1'b0; bus.len_i = '0; bus.use_c_i = 1'b0; bus.op_valid_i = 1'b0;
    a_drv = '0; b_drv = '0;
    test_reset();
    test_basic();
    test_use_c();
    test_bubble();
    test_ignored_starts();
    test_n1();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
